// File: rtl/vec_hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vec_hazard_pkg
//  Brief    : Shared types and constants for the vector hazard unit.
//  Revision : 1.0
// ============================================================================
package vec_hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_WB  = 2'd1,
    FWD_MEM = 2'd2
  } fwd_sel_e;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    STALL = 1'b1
  } hz_state_e;

  localparam int REG_ZERO = 0;

endpackage
`default_nettype wire

// File: rtl/vec_fwd_mux.sv
`default_nettype none
// ============================================================================
//  Module   : vec_fwd_mux
//  Brief    : Single-source operand bypass: MEM/WB match and 3:1 select.
//  Revision : 1.0
// ============================================================================
module vec_fwd_mux
  import vec_hazard_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int REG_AW = 4
) (
  input  logic [REG_AW-1:0] src,
  input  logic              src_rd,
  input  logic              vf,
  input  logic [DATA_W-1:0] rf_data,
  input  logic [REG_AW-1:0] mem_dst,
  input  logic              mem_we,
  input  logic              mem_vf,
  input  logic [DATA_W-1:0] mem_res,
  input  logic [REG_AW-1:0] wb_dst,
  input  logic              wb_we,
  input  logic              wb_vf,
  input  logic [DATA_W-1:0] wb_res,
  output logic [DATA_W-1:0] opnd,
  output logic [1:0]        sel
);

  localparam logic [REG_AW-1:0] c_reg_zero = REG_AW'(REG_ZERO);

  logic w_src_live;
  logic w_mem_hit;
  logic w_wb_hit;

  // The zero register is constant, so it never takes a bypassed value.
  assign w_src_live = src_rd && (src != c_reg_zero);
  assign w_mem_hit  = w_src_live && mem_we && (src == mem_dst) && (vf == mem_vf);
  assign w_wb_hit   = w_src_live && wb_we  && (src == wb_dst)  && (vf == wb_vf);

  always_comb begin
    opnd = rf_data;
    sel  = FWD_RF;
    if (w_mem_hit) begin
      opnd = mem_res;
      sel  = FWD_MEM;
    end else if (w_wb_hit) begin
      opnd = wb_res;
      sel  = FWD_WB;
    end
  end

endmodule
`default_nettype wire

// File: rtl/vec_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module   : vec_hazard_unit
//  Brief    : EX-stage operand forwarding plus load-use stall FSM and counter.
//  Revision : 1.0
// ============================================================================
module vec_hazard_unit
  import vec_hazard_pkg::*;
#(
  parameter int DATA_W  = 128,
  parameter int REG_AW  = 4,
  parameter int NUM_SRC = 3,
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_SRC-1:0][REG_AW-1:0]   ex_src,
  input  logic [NUM_SRC-1:0]               ex_src_rd,
  input  logic                             ex_vf,
  input  logic [NUM_SRC-1:0][DATA_W-1:0]   ex_rf_data,
  input  logic [REG_AW-1:0]                mem_dst,
  input  logic [REG_AW-1:0]                wb_dst,
  input  logic                             mem_we,
  input  logic                             wb_we,
  input  logic                             mem_vf,
  input  logic                             wb_vf,
  input  logic [DATA_W-1:0]                mem_res,
  input  logic [DATA_W-1:0]                wb_res,
  input  logic [NUM_SRC-1:0][REG_AW-1:0]   id_src,
  input  logic [NUM_SRC-1:0]               id_src_rd,
  input  logic                             id_vf,
  input  logic [REG_AW-1:0]                ex_dst,
  input  logic                             ex_is_load,
  input  logic                             ex_vf_dst,
  input  logic                             flush,
  output logic [NUM_SRC-1:0][DATA_W-1:0]   ex_opnd,
  output logic [NUM_SRC-1:0][1:0]          fwd_sel,
  output logic                             stall,
  output logic                             bubble,
  output logic [CNT_W-1:0]                 stall_cnt
);

  localparam int                c_cnt_w    = $clog2(MEM_LAT + 1);
  localparam logic [REG_AW-1:0] c_reg_zero = REG_AW'(REG_ZERO);

  hz_state_e          r_state;
  hz_state_e          w_state_nxt;
  logic [c_cnt_w-1:0] r_cnt;
  logic [c_cnt_w-1:0] w_cnt_nxt;
  logic [CNT_W-1:0]   r_stall_cnt;
  logic               w_hazard;
  logic               w_stall;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    vec_fwd_mux #(
      .DATA_W (DATA_W),
      .REG_AW (REG_AW)
    ) u_fwd_mux (
      .src     (ex_src[gi]),
      .src_rd  (ex_src_rd[gi]),
      .vf      (ex_vf),
      .rf_data (ex_rf_data[gi]),
      .mem_dst (mem_dst),
      .mem_we  (mem_we),
      .mem_vf  (mem_vf),
      .mem_res (mem_res),
      .wb_dst  (wb_dst),
      .wb_we   (wb_we),
      .wb_vf   (wb_vf),
      .wb_res  (wb_res),
      .opnd    (ex_opnd[gi]),
      .sel     (fwd_sel[gi])
    );
  end

  // Load-use: an ID source depends on the load currently in EX.
  always_comb begin
    w_hazard = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (id_src_rd[i] && (id_src[i] != c_reg_zero) && ex_is_load &&
          (id_src[i] == ex_dst) && (id_vf == ex_vf_dst))
        w_hazard = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stall     = 1'b0;
    if (flush) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_hazard) begin
            w_stall = 1'b1;
            if (MEM_LAT > 1) begin
              w_state_nxt = STALL;
              w_cnt_nxt   = c_cnt_w'(MEM_LAT - 1);
            end
          end
        end
        STALL: begin
          w_stall   = 1'b1;
          w_cnt_nxt = r_cnt - c_cnt_w'(1);
          if (r_cnt == c_cnt_w'(1))
            w_state_nxt = IDLE;
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_stall && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign stall     = w_stall;
  assign bubble    = w_stall;
  assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire
